fir_coeff_bank: RTL and testbench

- Double-buffered, run-time reloadable coefficient store for the symmetric wavelet/FIR datapath. Holds the unique half of the symmetric taps, h[0] to h[NUM_COEFFS-1], in the same flattened layout the filter already consumes.
- Coefficients stream into a shadow bank over a valid/ready interface. The filter keeps using the active bank during the load.
- A swap request, issued at a frame boundary, makes the loaded set active with no glitch in the coefficient set.

---
 rtl/fir_coeff_bank.sv | 118 +++++++++++
 tb/tb_fir_coeff_bank.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store: a load streams into the shadow bank while the filter keeps reading
// the active bank; a frame-boundary swap makes a completely loaded set active in a single edge.
module fir_coeff_bank #(
  parameter int unsigned COEFF_WIDTH = 21,
  parameter int unsigned NUM_COEFFS  = 90,
  parameter int unsigned CNT_WIDTH   = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [COEFF_WIDTH-1:0]            wr_data_i,
  input  logic                              wr_last_i,
  input  logic                              load_abort_i,
  input  logic                              swap_req_i,
  output logic                              swap_ack_o,
  output logic                              pending_o,
  output logic                              load_err_o,
  output logic                              bank_sel_o,
  output logic                              coeff_valid_o,
  output logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_COEFFS - 1);

  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   bank_sel_q, bank_sel_d;
  logic                   coeff_valid_q, coeff_valid_d;
  logic                   swap_ack_q, swap_ack_d;
  logic                   load_err_q, load_err_d;
  logic                   pending_q;
  logic                   wr_ready_q;
  logic                   wr_en;
  logic [COEFF_WIDTH-1:0] bank_q [2][NUM_COEFFS];

  // Next-state: abort beats swap, swap beats a write handshake.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bank_sel_d    = bank_sel_q;
    coeff_valid_d = coeff_valid_q;
    swap_ack_d    = 1'b0;
    load_err_d    = 1'b0;
    wr_en         = 1'b0;
    if (load_abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (swap_req_i && (state_q == ST_PEND)) begin
      bank_sel_d    = ~bank_sel_q;
      coeff_valid_d = 1'b1;
      swap_ack_d    = 1'b1;
      state_d       = ST_IDLE;
    end else if (wr_valid_i && (state_q != ST_PEND)) begin
      if (wr_last_i && (cnt_q == LAST_IDX)) begin
        wr_en   = 1'b1;
        state_d = ST_PEND;
        cnt_d   = '0;
      end else if (wr_last_i || (cnt_q == LAST_IDX)) begin
        load_err_d = 1'b1;
        state_d    = ST_IDLE;
        cnt_d      = '0;
      end else begin
        wr_en   = 1'b1;
        state_d = ST_LOAD;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State, status flags and bank storage; reset clears both banks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bank_sel_q    <= 1'b0;
      coeff_valid_q <= 1'b0;
      swap_ack_q    <= 1'b0;
      load_err_q    <= 1'b0;
      pending_q     <= 1'b0;
      wr_ready_q    <= 1'b1;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < int'(NUM_COEFFS); k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bank_sel_q    <= bank_sel_d;
      coeff_valid_q <= coeff_valid_d;
      swap_ack_q    <= swap_ack_d;
      load_err_q    <= load_err_d;
      pending_q     <= (state_d == ST_PEND);
      wr_ready_q    <= (state_d != ST_PEND);
      if (wr_en) begin
        bank_q[~bank_sel_q][cnt_q] <= wr_data_i;
      end
    end
  end

  // Shadow bank is never selected until a complete load has been swapped in.
  for (genvar k = 0; k < int'(NUM_COEFFS); k++) begin : g_out
    assign coeffs_o[COEFF_WIDTH*k +: COEFF_WIDTH] = bank_q[bank_sel_q][k];
  end

  assign wr_ready_o    = wr_ready_q;
  assign pending_o     = pending_q;
  assign swap_ack_o    = swap_ack_q;
  assign load_err_o    = load_err_q;
  assign bank_sel_o    = bank_sel_q;
  assign coeff_valid_o = coeff_valid_q;

endmodule

// File: tb/tb_fir_coeff_bank.sv
// Scoreboard bench for fir_coeff_bank: a cycle model predicts every post-edge output and a
// monitor compares them after each rising edge; directed checks cover the key scenarios.
module tb_fir_coeff_bank;

  localparam int CW = 21;
  localparam int NC = 90;
  localparam int VW = CW * NC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_last, load_abort, swap_req;
  logic [CW-1:0] wr_data;
  logic          wr_ready, swap_ack, pending, load_err, bank_sel, coeff_valid;
  logic [VW-1:0] coeffs;

  fir_coeff_bank #(.COEFF_WIDTH(CW), .NUM_COEFFS(NC), .CNT_WIDTH(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_data_i    (wr_data),
    .wr_last_i    (wr_last),
    .load_abort_i (load_abort),
    .swap_req_i   (swap_req),
    .swap_ack_o   (swap_ack),
    .pending_o    (pending),
    .load_err_o   (load_err),
    .bank_sel_o   (bank_sel),
    .coeff_valid_o(coeff_valid),
    .coeffs_o     (coeffs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy, pend, ack, err, sel, vld;
    logic [VW-1:0] co;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int            m_st;      // 0 idle, 1 load, 2 pend
  int            m_cnt;
  logic          m_sel, m_vld, m_ack, m_err;
  logic [CW-1:0] m_bank [2][NC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge and queue the predicted outputs.
  task automatic model_edge(input logic r, v, input logic [CW-1:0] d, input logic l, ab, sw);
    exp_t x;
    if (!r) begin
      m_st = 0; m_cnt = 0; m_sel = 0; m_vld = 0; m_ack = 0; m_err = 0;
      for (int b = 0; b < 2; b++) for (int k = 0; k < NC; k++) m_bank[b][k] = '0;
    end else begin
      m_ack = 0;
      m_err = 0;
      if (ab && m_st != 0) begin
        m_st = 0; m_cnt = 0;
      end else if (sw && m_st == 2) begin
        m_sel = !m_sel; m_vld = 1; m_ack = 1; m_st = 0;
      end else if (v && m_st != 2) begin
        if (l != (m_cnt == NC - 1)) begin
          m_err = 1; m_st = 0; m_cnt = 0;
        end else begin
          m_bank[!m_sel][m_cnt] = d;
          if (l) begin m_st = 2; m_cnt = 0; end
          else begin m_st = 1; m_cnt++; end
        end
      end
    end
    x.rdy = (m_st != 2); x.pend = (m_st == 2); x.ack = m_ack; x.err = m_err;
    x.sel = m_sel; x.vld = m_vld;
    for (int k = 0; k < NC; k++) x.co[k*CW +: CW] = m_bank[m_sel][k];
    sb_q.push_back(x);
  endtask

  // Drive one cycle at the falling edge; returns just after the following rising edge.
  task automatic step(input logic r, v, input logic [CW-1:0] d, input logic l, ab, sw);
    @(negedge clk);
    rst_n = r; wr_valid = v; wr_data = d; wr_last = l; load_abort = ab; swap_req = sw;
    model_edge(r, v, d, l, ab, sw);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(); step(1, 0, '0, 0, 0, 0); endtask

  // Stream n words starting at word 0; pattern 0: k+1, 1: 1FFFFF-k, 2: 3k+7.
  task automatic load(input int n, input int pat, input logic last_on_end, input logic gaps);
    logic [CW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = (pat == 0) ? CW'(k + 1) : (pat == 1) ? (21'h1FFFFF - CW'(k)) : CW'(3 * k + 7);
      if (gaps) step(1, 0, 21'h0AAAAA, 1, 0, 0);
      step(1, 1, d, last_on_end && (k == n - 1), 0, 0);
    end
  endtask

  // Directed check of the visible coefficient set against a freshly computed pattern (3 = all zero).
  task automatic chk_set(input string tag, input int pat);
    logic [CW-1:0] w;
    int bad = 0;
    for (int k = 0; k < NC; k++) begin
      w = (pat == 0) ? CW'(k + 1) : (pat == 1) ? (21'h1FFFFF - CW'(k)) : (pat == 2) ? CW'(3 * k + 7) : '0;
      if (coeffs[k*CW +: CW] !== w) begin bad = k; break; end
    end
    w = (pat == 0) ? CW'(bad + 1) : (pat == 1) ? (21'h1FFFFF - CW'(bad)) : (pat == 2) ? CW'(3 * bad + 7) : '0;
    chk(tag, 64'(coeffs[bad*CW +: CW]), 64'(w));
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      int bad;
      e = sb_q.pop_front();
      chk("wr_ready", 64'(wr_ready), 64'(e.rdy));
      chk("pending", 64'(pending), 64'(e.pend));
      chk("swap_ack", 64'(swap_ack), 64'(e.ack));
      chk("load_err", 64'(load_err), 64'(e.err));
      chk("bank_sel", 64'(bank_sel), 64'(e.sel));
      chk("coeff_valid", 64'(coeff_valid), 64'(e.vld));
      bad = 0;
      for (int k = 0; k < NC; k++) begin
        if (coeffs[k*CW +: CW] !== e.co[k*CW +: CW]) begin bad = k; break; end
      end
      chk("coeffs", 64'(coeffs[bad*CW +: CW]), 64'(e.co[bad*CW +: CW]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; wr_valid = 0; wr_data = '0; wr_last = 0; load_abort = 0; swap_req = 0;
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    chk("rst_sel", 64'(bank_sel), 64'd0);
    chk_set("rst_zero", 3);
    idle();

    // Set A, then swap
    load(NC, 0, 1, 0);
    chk("A_pending", 64'(pending), 64'd1);
    chk("A_ready", 64'(wr_ready), 64'd0);
    step(1, 0, '0, 0, 0, 1);
    chk("A_ack", 64'(swap_ack), 64'd1);
    chk("A_sel", 64'(bank_sel), 64'd1);
    chk("A_valid", 64'(coeff_valid), 64'd1);
    chk_set("A_set", 0);
    idle();
    chk("A_ack_pulse", 64'(swap_ack), 64'd0);

    // Set B with gaps; A stays visible until the swap
    load(NC, 1, 1, 1);
    chk_set("B_hold_A", 0);
    step(1, 0, '0, 0, 0, 1);
    chk("B_ack", 64'(swap_ack), 64'd1);
    chk("B_sel", 64'(bank_sel), 64'd0);
    chk_set("B_set", 1);
    idle();

    // Early wr_last on word 50
    load(50, 2, 0, 0);
    step(1, 1, 21'h12345, 1, 0, 0);
    chk("err_pulse", 64'(load_err), 64'd1);
    chk("err_pend", 64'(pending), 64'd0);
    chk("err_sel", 64'(bank_sel), 64'd0);
    chk_set("err_keepB", 1);
    idle();
    chk("err_pulse_end", 64'(load_err), 64'd0);
    load(NC, 2, 1, 0);
    step(1, 0, '0, 0, 0, 1);
    chk("err_recover_ack", 64'(swap_ack), 64'd1);
    chk_set("err_recover_set", 2);

    // Missing wr_last on the final word
    load(NC - 1, 0, 0, 0);
    step(1, 1, 21'h00042, 0, 0, 0);
    chk("nolast_err", 64'(load_err), 64'd1);

    // Swap coincident with last word is ignored; wr_valid held in PEND is refused
    load(NC - 1, 0, 0, 0);
    step(1, 1, CW'(NC), 1, 0, 1);
    chk("coinc_noack", 64'(swap_ack), 64'd0);
    chk("coinc_pend", 64'(pending), 64'd1);
    for (int i = 0; i < 4; i++) step(1, 1, 21'h1DEAD, i == 3, 0, 0);
    chk("pend_ready", 64'(wr_ready), 64'd0);
    step(1, 1, 21'h1BEEF, 0, 0, 1);
    chk("pend_ack", 64'(swap_ack), 64'd1);
    chk_set("pend_set", 0);

    // Abort beats swap in PEND
    load(NC, 1, 1, 0);
    step(1, 0, '0, 0, 1, 1);
    chk("abort_noack", 64'(swap_ack), 64'd0);
    chk("abort_pend", 64'(pending), 64'd0);
    chk("abort_err", 64'(load_err), 64'd0);
    chk_set("abort_keep", 0);
    // Abort at word 30 drops that word and restarts the count
    load(30, 2, 0, 0);
    step(1, 1, 21'h0F0F0, 0, 1, 0);
    step(1, 0, '0, 0, 1, 0);
    load(NC, 1, 1, 0);
    step(1, 0, '0, 0, 0, 1);
    chk("abort_reload_ack", 64'(swap_ack), 64'd1);
    chk_set("abort_reload_set", 1);

    // Reset during word 40 of a load after prior swaps
    load(40, 2, 0, 0);
    step(0, 1, 21'h0ABCD, 0, 0, 0);
    chk("mrst_sel", 64'(bank_sel), 64'd0);
    chk("mrst_valid", 64'(coeff_valid), 64'd0);
    chk("mrst_ready", 64'(wr_ready), 64'd1);
    chk_set("mrst_zero", 3);
    load(NC, 0, 1, 0);
    step(1, 0, '0, 0, 0, 1);
    chk_set("post_rst_set", 0);
    idle();
    idle();

    @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
